// File: rtl/addsub_arbiter_pkg.sv
// rtl/addsub_arbiter_pkg.sv - shared constants, state encoding and round-robin helpers
package addsub_arbiter_pkg;

    localparam int NREQ = 3;
    localparam int DW   = 16;

    localparam logic [DW-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DW-1:0] SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // First requester found when searching upward from ptr, wrapping at NREQ.
    function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req, input logic [1:0] ptr);
        logic [2:0] s;
        logic [1:0] idx;
        rr_pick = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            s   = {1'b0, ptr} + 3'(k);
            idx = (s >= 3'(NREQ)) ? 2'(s - 3'(NREQ)) : s[1:0];
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
        onehot = NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/addsub_arbiter_if.sv
// rtl/addsub_arbiter_if.sv - requester-side bus of the shared add/sub unit
interface addsub_arbiter_if;
    import addsub_arbiter_pkg::*;

    logic [NREQ-1:0] req;
    logic [DW-1:0]   a0, a1, a2;
    logic [DW-1:0]   b0, b1, b2;
    logic [NREQ-1:0] sub;
    logic [NREQ-1:0] sat;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] vld;
    logic [DW-1:0]   res;
    logic            ovfl;
    logic            busy;

    modport master (
        output req, a0, a1, a2, b0, b1, b2, sub, sat,
        input  gnt, vld, res, ovfl, busy
    );

    modport slave (
        input  req, a0, a1, a2, b0, b1, b2, sub, sat,
        output gnt, vld, res, ovfl, busy
    );

endinterface

// File: rtl/addsub_arbiter_adder.sv
// rtl/addsub_arbiter_adder.sv - 16-bit two's-complement adder/subtractor with overflow flag
module addsub_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum,
    output logic        ovfl
);

    logic [15:0] b_eff;

    // Subtract as A + ~B + 1; the carry-out is dropped by the 16-bit sum.
    assign b_eff = b ^ {16{sub}};
    assign sum   = a + b_eff + {15'd0, sub};
    // Overflow when both addends share a sign that the sum does not.
    assign ovfl  = (a[15] == b_eff[15]) && (sum[15] != a[15]);

endmodule

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin arbiter sharing one add/sub datapath among three requesters
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int NREQ = addsub_arbiter_pkg::NREQ
) (
    input  logic              clk,
    input  logic              rst,
    addsub_arbiter_if.slave   bus
);

    state_t          state_q, state_d;
    logic            take;
    logic [1:0]      win;
    logic [1:0]      ptr_q;
    logic [1:0]      owner_q;
    logic [DW-1:0]   op_a_q, op_b_q;
    logic            op_sub_q, op_sat_q;
    logic [DW-1:0]   res_q;
    logic            ovfl_q;
    logic [NREQ-1:0] vld_q;
    logic [DW-1:0]   sel_a, sel_b;
    logic [DW-1:0]   add_sum, res_fin;
    logic            add_ovfl;

    assign win = rr_pick(bus.req, ptr_q);

    // Operand steering from the winning requester.
    always_comb begin
        sel_a = bus.a0;
        sel_b = bus.b0;
        case (win)
            2'd1: begin
                sel_a = bus.a1;
                sel_b = bus.b1;
            end
            2'd2: begin
                sel_a = bus.a2;
                sel_b = bus.b2;
            end
            default: begin
                sel_a = bus.a0;
                sel_b = bus.b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and grant decision; a new grant may overlap the response cycle.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (!rst && (|bus.req)) begin
                    take    = 1'b1;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    addsub_16bit u_addsub (
        .a    (op_a_q),
        .b    (op_b_q),
        .sub  (op_sub_q),
        .sum  (add_sum),
        .ovfl (add_ovfl)
    );

    assign res_fin = (op_sat_q && add_ovfl) ? (op_a_q[DW-1] ? SAT_NEG : SAT_POS) : add_sum;

    // Operand latch on grant, result capture in EXEC, single-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= 2'd0;
            owner_q  <= 2'd0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_sub_q <= 1'b0;
            op_sat_q <= 1'b0;
            res_q    <= '0;
            ovfl_q   <= 1'b0;
            vld_q    <= '0;
        end else begin
            vld_q <= '0;
            if (take) begin
                ptr_q    <= (win == 2'd2) ? 2'd0 : win + 2'd1;
                owner_q  <= win;
                op_a_q   <= sel_a;
                op_b_q   <= sel_b;
                op_sub_q <= bus.sub[win];
                op_sat_q <= bus.sat[win];
            end
            if (state_q == ST_EXEC) begin
                res_q  <= res_fin;
                ovfl_q <= add_ovfl;
                vld_q  <= onehot(owner_q);
            end
        end
    end

    assign bus.gnt  = take ? onehot(win) : '0;
    assign bus.vld  = vld_q;
    assign bus.res  = res_q;
    assign bus.ovfl = ovfl_q;
    assign bus.busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - directed self-checking bench for addsub_arbiter
module tb_addsub_arbiter;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    addsub_arbiter_if bus ();

    addsub_arbiter #(.NREQ(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                           input logic s, input logic st);
        case (idx)
            0: begin bus.a0 = a; bus.b0 = b; end
            1: begin bus.a1 = a; bus.b1 = b; end
            default: begin bus.a2 = a; bus.b2 = b; end
        endcase
        bus.sub[idx] = s;
        bus.sat[idx] = st;
    endtask

    // Single request: gnt at T, EXEC at T+1, vld at T+2. Operands are
    // scrambled after the grant to show the latched copy is used.
    task automatic do_op(input string tag, input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic st, input logic [15:0] er, input logic eo);
        logic [2:0] eg;
        eg = 3'b001 << idx;
        @(posedge clk); #1;
        load_op(idx, a, b, s, st);
        bus.req = eg;
        @(negedge clk);
        check_val({tag, " gnt"}, 32'(bus.gnt), 32'(eg));
        @(posedge clk); #1;
        bus.req = 3'b000;
        load_op(idx, 16'hDEAD, 16'hBEEF, ~s, ~st);
        @(negedge clk);
        check_val({tag, " exec vld"}, 32'(bus.vld), 32'd0);
        check_val({tag, " exec busy"}, 32'(bus.busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check_val({tag, " vld"}, 32'(bus.vld), 32'(eg));
        check_val({tag, " res"}, 32'(bus.res), 32'(er));
        check_val({tag, " ovfl"}, 32'(bus.ovfl), 32'(eo));
    endtask

    task automatic step_check(input string tag, input logic [2:0] eg, input logic [2:0] ev,
                              input logic [15:0] er, input logic chk_res);
        @(posedge clk);
        @(negedge clk);
        check_val({tag, " gnt"}, 32'(bus.gnt), 32'(eg));
        check_val({tag, " vld"}, 32'(bus.vld), 32'(ev));
        if (chk_res) check_val({tag, " res"}, 32'(bus.res), 32'(er));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        bus.req = 3'b000;
        bus.sub = 3'b000;
        bus.sat = 3'b000;
        bus.a0 = '0; bus.a1 = '0; bus.a2 = '0;
        bus.b0 = '0; bus.b1 = '0; bus.b2 = '0;

        // Reset with all three requesting: gnt held low, outputs cleared.
        load_op(0, 16'h0001, 16'h0002, 1'b0, 1'b0);
        load_op(1, 16'h000A, 16'h0003, 1'b1, 1'b0);
        load_op(2, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        bus.req = 3'b111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst gnt", 32'(bus.gnt), 32'd0);
        check_val("rst vld", 32'(bus.vld), 32'd0);
        check_val("rst busy", 32'(bus.busy), 32'd0);
        check_val("rst res", 32'(bus.res), 32'd0);
        check_val("rst ovfl", 32'(bus.ovfl), 32'd0);

        // All requesting from reset: grants 0,1,2,0 two cycles apart.
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rr T gnt", 32'(bus.gnt), 32'b001);
        step_check("rr T+1", 3'b000, 3'b000, 16'h0000, 1'b0);
        check_val("rr T+1 busy", 32'(bus.busy), 32'd1);
        step_check("rr T+2", 3'b010, 3'b001, 16'h0003, 1'b1);
        step_check("rr T+3", 3'b000, 3'b000, 16'h0003, 1'b1);
        step_check("rr T+4", 3'b100, 3'b010, 16'h0007, 1'b1);
        step_check("rr T+5", 3'b000, 3'b000, 16'h0007, 1'b1);
        step_check("rr T+6", 3'b001, 3'b100, 16'h7FFF, 1'b1);
        check_val("rr T+6 ovfl", 32'(bus.ovfl), 32'd1);
        @(posedge clk); #1;
        bus.req = 3'b000;
        @(negedge clk);
        check_val("rr T+7 vld", 32'(bus.vld), 32'd0);
        step_check("rr T+8", 3'b000, 3'b001, 16'h0003, 1'b1);
        check_val("rr T+8 ovfl", 32'(bus.ovfl), 32'd0);
        step_check("rr T+9", 3'b000, 3'b000, 16'h0003, 1'b1);
        check_val("rr T+9 busy", 32'(bus.busy), 32'd0);

        // Arithmetic corner cases, one requester at a time.
        do_op("add small",    0, 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0);
        do_op("sub neg sat",  1, 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1);
        do_op("sub neg wrap", 1, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1);
        do_op("add pos sat",  2, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1);
        do_op("add to zero",  2, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b0);
        do_op("sub plain",    0, 16'h1234, 16'h0234, 1'b1, 1'b0, 16'h1000, 1'b0);
        do_op("sub min wrap", 1, 16'h0000, 16'h8000, 1'b1, 1'b0, 16'h8000, 1'b1);
        do_op("sub min sat",  1, 16'h0000, 16'h8000, 1'b1, 1'b1, 16'h7FFF, 1'b1);
        do_op("add neg wrap", 2, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
        do_op("add neg ok",   0, 16'hFFFE, 16'h0003, 1'b0, 1'b0, 16'h0001, 1'b0);

        // Result and flag hold between pulses.
        step_check("hold 1", 3'b000, 3'b000, 16'h0001, 1'b1);
        step_check("hold 2", 3'b000, 3'b000, 16'h0001, 1'b1);
        check_val("hold busy", 32'(bus.busy), 32'd0);

        // Fresh reset, req0 continuous, req1 joins one cycle later: 0,1,0,1.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        load_op(0, 16'h0005, 16'h0001, 1'b0, 1'b0);
        load_op(1, 16'h0009, 16'h0004, 1'b1, 1'b0);
        bus.req = 3'b001;
        @(negedge clk);
        check_val("alt T gnt", 32'(bus.gnt), 32'b001);
        @(posedge clk); #1;
        bus.req = 3'b011;
        @(negedge clk);
        check_val("alt T+1 gnt", 32'(bus.gnt), 32'd0);
        step_check("alt T+2", 3'b010, 3'b001, 16'h0006, 1'b1);
        step_check("alt T+3", 3'b000, 3'b000, 16'h0006, 1'b1);
        step_check("alt T+4", 3'b001, 3'b010, 16'h0005, 1'b1);
        step_check("alt T+5", 3'b000, 3'b000, 16'h0005, 1'b1);
        step_check("alt T+6", 3'b010, 3'b001, 16'h0006, 1'b1);
        @(posedge clk); #1;
        bus.req = 3'b000;
        @(negedge clk);
        step_check("alt T+8", 3'b000, 3'b010, 16'h0005, 1'b1);

        // Reset during EXEC discards the operation.
        @(posedge clk); #1;
        load_op(1, 16'h0100, 16'h0011, 1'b0, 1'b0);
        bus.req = 3'b010;
        @(negedge clk);
        check_val("rexec gnt", 32'(bus.gnt), 32'b010);
        @(posedge clk); #1;
        bus.req = 3'b000;
        rst = 1'b1;
        @(negedge clk);
        check_val("rexec busy", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rexec vld", 32'(bus.vld), 32'd0);
        check_val("rexec busy idle", 32'(bus.busy), 32'd0);
        check_val("rexec res", 32'(bus.res), 32'd0);
        check_val("rexec ovfl", 32'(bus.ovfl), 32'd0);
        step_check("rexec after", 3'b000, 3'b000, 16'h0000, 1'b1);
        do_op("post rst", 0, 16'h0100, 16'h0011, 1'b0, 1'b0, 16'h0111, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of requesters (fixed 3 in this revision).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req, input, 3, per-requester request; held high with operands stable until the matching gnt.
REQ-005 SHALL have ports a0/a1/a2 and b0/b1/b2, input, 16 each, signed two's-complement operands per requester.
REQ-006 SHALL have port sub, input, 3, per-requester op select: 1 = A-B, 0 = A+B.
REQ-007 SHALL have port sat, input, 3, per-requester saturate enable.
REQ-008 SHALL have port gnt, output, 3, one-hot combinational accept pulse, operands latched this cycle.
REQ-009 SHALL have port vld, output, 3, one-hot registered result-valid pulse to the owning requester.
REQ-010 SHALL have port res, output, 16, shared result bus, meaningful when any vld bit is high.
REQ-011 SHALL have port ovfl, output, 1, signed overflow of the raw A±B, qualified by vld.
REQ-012 SHALL have port busy, output, 1, high in EXEC and RESP.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-014 IDLE: no req -> stay IDLE; any req -> assert gnt for the winner, latch a/b/sub/sat/owner id, go EXEC.
REQ-015 EXEC: drive latched operands into the shared adder; register the sum, ovfl and final result; go RESP.
REQ-016 RESP: vld[owner] high exactly one cycle, res/ovfl from registers; same-cycle grant allowed (any req -> gnt + latch, go EXEC; else IDLE).
REQ-017 Latency: gnt in cycle T -> vld in cycle T+2; peak throughput one operation per 2 cycles.
REQ-018 Arbitration SHALL be round-robin: search order starts at (last owner + 1) mod 3; at most one gnt bit per cycle; gnt never asserted in EXEC.
REQ-019 Priority pointer SHALL advance only on a grant; a request never waits more than 2 other grants.
REQ-020 Subtraction SHALL be A + ~B + 1 (inverted B, carry-in = sub); result width 16 bits, carry-out discarded.
REQ-021 ovfl SHALL be 1 iff the true signed result lies outside [-32768, 32767].
REQ-022 sat=1 and ovfl=1: res SHALL be 0x7FFF if A[15]=0, else 0x8000; sat=0: res SHALL be the wrapped 16-bit sum.
REQ-023 ovfl SHALL report raw overflow regardless of sat.
REQ-024 Requests dropped before gnt SHALL be ignored; req changes after gnt SHALL not affect the latched operation.
REQ-025 res and ovfl SHALL hold their last values between vld pulses.

Reset
REQ-026 rst high at any edge SHALL force IDLE, pointer to requester 0 highest priority, res=0x0000, ovfl=0, vld=0, busy=0.
REQ-027 gnt SHALL be 0 while rst is high; an in-flight operation SHALL be discarded with no vld.

Structure
REQ-028 State encodings, NREQ, SAT_POS=0x7FFF and SAT_NEG=0x8000 SHALL live in a shared package/include file.
REQ-029 The design SHALL instantiate exactly one addsub_16bit as the shared datapath; no other adder on the operand path.
REQ-030 Arbiter, operand/result registers and saturation mux SHALL be in this module; no further sub-modules.

Verification
REQ-031 req0 only, 0x0003+0x0004 sat=0 -> gnt0 at T, vld0 at T+2, res 0x0007, ovfl 0.
REQ-032 req1, 0x8000-0x0001: sat=1 -> res 0x8000 ovfl 1; sat=0 -> res 0x7FFF ovfl 1.
REQ-033 req2, 0x7FFF+0x0001 sat=1 -> res 0x7FFF ovfl 1; 0xFFFF+0x0001 -> res 0x0000 ovfl 0.
REQ-034 After reset, req=3'b111 held -> gnt order 0,1,2 at T, T+2, T+4, each vld two cycles after its gnt, correct owner.
REQ-035 req0 continuous, req1 asserted at T+1 -> grants alternate 0,1,0,1; no starvation.
REQ-036 rst pulsed in EXEC -> next cycle IDLE, no vld, res 0x0000, busy 0; next req granted normally.
